// File: rtl/ram8_bank.sv
// ram8_bank: eight-word register memory with a sequenced clear engine.
//
// Words are written through a one-hot decode of `address` and read back
// through a combinational 8:1 mux. A clear request starts a sweep that
// zeroes one word per cycle, word 0 first, while writes are blocked.
//
// Optional feature macro: RAM8_BYPASS_EN
//   defined   : a pending write (load high, not busy) is shown on `out`
//               in the same cycle, ahead of the storing edge.
//   undefined : `out` always shows the stored word.
//
// State table:
//   state | meaning
//   IDLE  | accepting writes, waiting for a clear request
//   CLEAR | zeroing word[ptr] each edge; writes and clear requests ignored

module ram8_bank #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       ptr;
    logic [2:0]       ptr_nxt;
    logic [7:0]       we;
    logic [7:0]       sweep;
    logic [WIDTH-1:0] mem [8];
    logic [WIDTH-1:0] rd_word;

    // busy comes straight from the state register, so it is glitch-free and
    // rises the cycle after clear is sampled.
    assign busy = (state == CLEAR);

    // State and sweep pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state logic: one pass over all eight words, then back to IDLE.
    // A clear still high on return starts a fresh sweep from IDLE.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = 3'd0;
                end
            end
            CLEAR: begin
                ptr_nxt = ptr + 3'd1;
                if (ptr == 3'd7) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = 3'd0;
            end
        endcase
    end

    // One-hot write enable; loads arriving during a sweep are dropped.
    always_comb begin
        we = 8'd0;
        if (load && !busy) begin
            we[address] = 1'b1;
        end
    end

    // One-hot sweep select for the word being cleared this cycle.
    always_comb begin
        sweep = 8'd0;
        if (busy) begin
            sweep[ptr] = 1'b1;
        end
    end

    // Word storage. we and sweep are mutually exclusive because we is gated
    // by busy, so the order of the two branches only matters for clarity.
    for (genvar i = 0; i < 8; i++) begin : g_word
        // Store or zero word i on the rising edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem[i] <= '0;
            end else if (sweep[i]) begin
                mem[i] <= '0;
            end else if (we[i]) begin
                mem[i] <= in;
            end
        end
    end

    // 8:1 read mux, zero latency from address.
    always_comb begin
        rd_word = mem[address];
    end

    // Output select. Held at zero while reset is asserted so a bypassed
    // pending write cannot leak out during reset.
    always_comb begin
        out = rd_word;
`ifdef RAM8_BYPASS_EN
        if (load && !busy) begin
            out = in;
        end
`endif
        if (!rst_n) begin
            out = '0;
        end
    end

endmodule

// File: tb/tb_ram8_bank.sv
// tb_ram8_bank: randomized and directed checks of ram8_bank against a
// word-array reference model. Inputs change 1 time unit after a rising edge;
// outputs are sampled later in the same cycle.

module tb_ram8_bank;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             load;
    logic [2:0]       address;
    logic             clear;
    logic [WIDTH-1:0] dout;
    logic             busy;

    int checks;
    int errors;

    // reference model
    logic [WIDTH-1:0] m_mem [8];
    logic             m_busy;
    int               m_step;

    ram8_bank #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (din),
        .load    (load),
        .address (address),
        .clear   (clear),
        .out     (dout),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_busy = 1'b0;
        m_step = 0;
    endtask

    // Expected read value for the current inputs and model contents.
    function automatic logic [WIDTH-1:0] exp_out();
        if (!rst_n) return '0;
`ifdef RAM8_BYPASS_EN
        if (load && !m_busy) return din;
`endif
        return m_mem[address];
    endfunction

    // Apply one rising edge to the model, then advance the DUT past it.
    task automatic tick();
        if (rst_n) begin
            if (m_busy) begin
                m_mem[m_step] = '0;
                m_step++;
                if (m_step == 8) m_busy = 1'b0;
            end else begin
                if (load) m_mem[address] = din;
                if (clear) begin
                    m_busy = 1'b1;
                    m_step = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load  = 1'b0;
        clear = 1'b0;
        din   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        address = 3'd0;
        rst_n   = 1'b1;
        #3;
        rst_n = 1'b0;
        model_reset();
        #4;
        for (int a = 0; a < 8; a++) begin
            address = a[2:0];
            #1;
            checks++;
            if (dout !== 16'h0000) begin
                errors++;
                $display("FAIL reset_out addr %0d got %h want 0000", a, dout);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        load = 1'b1;
        din  = 16'h7E7E;
        #1;
        checks++;
        if (dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out_load got %h want 0000", dout);
        end
        idle_inputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        logic [WIDTH-1:0] want;
        load = 1'b1; address = 3'd3; din = 16'h1234; tick();
        load = 1'b1; address = 3'd7; din = 16'hBEEF; tick();
        idle_inputs();
        for (int a = 0; a < 8; a++) begin
            address = a[2:0];
            want = (a == 3) ? 16'h1234 : (a == 7) ? 16'hBEEF : 16'h0000;
            #1;
            checks++;
            if (dout !== want) begin
                errors++;
                $display("FAIL write_read addr %0d got %h want %h", a, dout, want);
            end
        end
    endtask

    task automatic test_clear_sweep();
        int busy_cycles;
        for (int i = 0; i < 8; i++) begin
            load = 1'b1; address = i[2:0]; din = 16'hA5A0 + WIDTH'(i); tick();
        end
        idle_inputs();
        clear = 1'b1; tick();
        clear = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (busy !== m_busy) begin
                errors++;
                $display("FAIL sweep_busy cycle %0d got %b want %b", c, busy, m_busy);
            end
            if (busy === 1'b1) busy_cycles++;
            for (int a = 0; a < 8; a++) begin
                address = a[2:0];
                #1;
                checks++;
                if (dout !== exp_out()) begin
                    errors++;
                    $display("FAIL sweep_read cycle %0d addr %0d got %h want %h", c, a, dout, exp_out());
                end
            end
            tick();
        end
        checks++;
        if (busy_cycles != 8) begin
            errors++;
            $display("FAIL sweep_length got %0d want 8", busy_cycles);
        end
    endtask

    task automatic test_load_during_sweep();
        int busy_cycles;
        for (int i = 0; i < 8; i++) begin
            load = 1'b1; address = i[2:0]; din = WIDTH'($urandom); tick();
        end
        idle_inputs();
        clear = 1'b1; tick();
        clear = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy === 1'b1) busy_cycles++;
            if (c == 2) begin
                load = 1'b1; address = 3'd5; din = 16'hFFFF; clear = 1'b1;
            end else if (c == 6) begin
                load = 1'b1; address = 3'd5; din = 16'hFFFF; clear = 1'b0;
            end else begin
                idle_inputs();
                address = 3'd5;
            end
            #1;
            checks++;
            if (dout !== exp_out() || busy !== m_busy) begin
                errors++;
                $display("FAIL busy_load cycle %0d got %h/%b want %h/%b", c, dout, busy, exp_out(), m_busy);
            end
            tick();
        end
        idle_inputs();
        address = 3'd5;
        #1;
        checks++;
        if (dout !== 16'h0000) begin
            errors++;
            $display("FAIL busy_load_word5 got %h want 0000", dout);
        end
        checks++;
        if (busy_cycles != 8) begin
            errors++;
            $display("FAIL busy_restart length got %0d want 8", busy_cycles);
        end
    endtask

    task automatic test_load_and_clear();
        load = 1'b1; clear = 1'b1; address = 3'd2; din = 16'h00C3; tick();
        idle_inputs();
        address = 3'd2;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (dout !== exp_out() || busy !== m_busy) begin
                errors++;
                $display("FAIL load_clear cycle %0d got %h/%b want %h/%b", c, dout, busy, exp_out(), m_busy);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] want;
        load = 1'b1; address = 3'd1; din = 16'h2222; tick();
        din = 16'h5555;
        #1;
`ifdef RAM8_BYPASS_EN
        want = 16'h5555;
`else
        want = 16'h2222;
`endif
        checks++;
        if (dout !== want) begin
            errors++;
            $display("FAIL bypass_pre_edge got %h want %h", dout, want);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (dout !== 16'h5555) begin
            errors++;
            $display("FAIL bypass_post_edge got %h want 5555", dout);
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < 8; i++) begin
            load = 1'b1; address = i[2:0]; din = 16'h1100 + WIDTH'(i); tick();
        end
        idle_inputs();
        clear = 1'b1; tick();
        clear = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_reset_busy got %b want 0", busy);
        end
        for (int a = 0; a < 8; a++) begin
            address = a[2:0];
            #1;
            checks++;
            if (dout !== 16'h0000) begin
                errors++;
                $display("FAIL midsweep_reset addr %0d got %h want 0000", a, dout);
            end
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            load    = ($urandom_range(0, 99) < 50);
            clear   = ($urandom_range(0, 99) < 4);
            address = 3'($urandom_range(0, 7));
            din     = WIDTH'($urandom);
            #1;
            checks++;
            if (dout !== exp_out() || busy !== m_busy) begin
                errors++;
                $display("FAIL random cycle %0d addr %0d got %h/%b want %h/%b", c, address, dout, busy, exp_out(), m_busy);
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 12; c++) tick();
        for (int a = 0; a < 8; a++) begin
            address = a[2:0];
            #1;
            checks++;
            if (dout !== m_mem[a]) begin
                errors++;
                $display("FAIL random_final addr %0d got %h want %h", a, dout, m_mem[a]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_write_read();
        test_clear_sweep();
        test_load_during_sweep();
        test_load_and_clear();
        test_bypass();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
